// File: rtl/t08_mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one
// downstream bus, with round-robin arbitration and a bus-ack timeout.
module t08_mem_arbiter #(
    parameter logic [7:0] TIMEOUT    = 8'd255,
    parameter logic       DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_sel,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        err,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        freeze
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        last_data_q, last_data_d;
    logic        gnt_data_q, gnt_data_d;
    logic        bus_read_q, bus_read_d;
    logic        bus_write_q, bus_write_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;

    logic        d_any;
    logic        pick_data;
    logic [7:0]  cnt_inc;
    logic [31:0] done_rdata;

    assign d_any   = d_read | d_write;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        last_data_d = last_data_q;
        gnt_data_d  = gnt_data_q;
        bus_read_d  = bus_read_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        pick_data   = 1'b0;
        done_rdata  = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (if_req | d_any) begin
                    // On contention the port that was not granted last wins.
                    pick_data   = d_any & (~if_req | ~last_data_q);
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    cnt_d       = 8'd0;
                    state_d     = S_ACCESS;
                    if (pick_data) begin
                        bus_write_d = d_write;
                        bus_read_d  = ~d_write;
                        bus_addr_d  = d_addr;
                        bus_wdata_d = d_wdata;
                        bus_sel_d   = d_write ? d_sel : 4'hF;
                    end else begin
                        bus_write_d = 1'b0;
                        bus_read_d  = 1'b1;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = 32'h0;
                        bus_sel_d   = 4'hF;
                    end
                end
            end
            S_ACCESS: begin
                // A real ack in the timeout cycle still completes cleanly.
                if (bus_ack || (cnt_inc == TIMEOUT)) begin
                    done_rdata  = bus_ack ? bus_rdata : 32'h0;
                    err_d       = ~bus_ack;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    state_d     = S_DONE;
                    if (gnt_data_q) begin
                        d_rdata_d = done_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = done_rdata;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            last_data_q <= ~DATA_FIRST;
            gnt_data_q  <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_sel_q   <= 4'h0;
            cnt_q       <= 8'd0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            gnt_data_q  <= gnt_data_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

    assign bus_read  = bus_read_q;
    assign bus_write = bus_write_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign freeze    = (if_req | d_any) & ~(if_ack_q | d_ack_q);

endmodule

// File: tb/tb_t08_mem_arbiter.sv
// Self-checking bench for t08_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_t08_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic        bus_read, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        freeze;

    t08_mem_arbiter #(.TIMEOUT(8'(TO)), .DATA_FIRST(1'b1)) dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sel(d_sel), .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .freeze(freeze)
    );

    always #5 clk = ~clk;

    // Transaction-level model: one outstanding access, then a one-cycle ack slot.
    typedef struct {
        bit          valid;
        bit          is_data;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waited;
    } txn_t;

    txn_t        cur;
    bit          m_ack_slot;
    bit          m_last_data;
    bit          m_if_ack, m_d_ack, m_err;
    logic [31:0] m_if_rdata, m_d_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur         = '{default: '0};
        m_ack_slot  = 1'b0;
        m_last_data = 1'b0;
        m_if_ack    = 1'b0;
        m_d_ack     = 1'b0;
        m_err       = 1'b0;
        m_if_rdata  = 32'h0;
        m_d_rdata   = 32'h0;
    endtask

    task automatic finish_txn(input logic [31:0] val, input bit e);
        if (cur.is_data) begin
            m_d_rdata = val;
            m_d_ack   = 1'b1;
        end else begin
            m_if_rdata = val;
            m_if_ack   = 1'b1;
        end
        m_err      = e;
        cur.valid  = 1'b0;
        m_ack_slot = 1'b1;
    endtask

    // Advance the model by one clock, using the inputs as sampled at this edge.
    task automatic model_step();
        bit want_if, want_d, take_d;
        m_if_ack = 1'b0;
        m_d_ack  = 1'b0;
        m_err    = 1'b0;
        if (m_ack_slot) begin
            m_ack_slot = 1'b0;
        end else if (cur.valid) begin
            if (bus_ack) begin
                finish_txn(bus_rdata, 1'b0);
            end else begin
                cur.waited++;
                if (cur.waited == TO) finish_txn(32'h0, 1'b1);
            end
        end else begin
            want_if = if_req;
            want_d  = d_read | d_write;
            if (want_if || want_d) begin
                take_d       = want_d && !(want_if && m_last_data);
                m_last_data  = take_d;
                cur.valid    = 1'b1;
                cur.is_data  = take_d;
                cur.is_write = take_d && d_write;
                cur.addr     = take_d ? d_addr : if_addr;
                cur.wdata    = d_wdata;
                cur.sel      = (take_d && d_write) ? d_sel : 4'hF;
                cur.waited   = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("bus_read", bus_read, cur.valid && !cur.is_write);
        check("bus_write", bus_write, cur.valid && cur.is_write);
        if (cur.valid) begin
            check("bus_addr", bus_addr, cur.addr);
            check("bus_sel", bus_sel, cur.sel);
            if (cur.is_write) check("bus_wdata", bus_wdata, cur.wdata);
        end
        check("if_ack", if_ack, m_if_ack);
        check("d_ack", d_ack, m_d_ack);
        check("err", err, m_err);
        check("if_rdata", if_rdata, m_if_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        check("freeze", freeze, (if_req | d_read | d_write) & ~(m_if_ack | m_d_ack));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    logic [31:0] exp_addr;
    int          n_acc;
    bit          seen;
    int          k;

    initial begin
        nrst      = 1'b0;
        if_req    = 1'b1;
        d_read    = 1'b1;
        d_write   = 1'b0;
        if_addr   = 32'h1000;
        d_addr    = 32'h2000;
        d_wdata   = 32'h0;
        d_sel     = 4'h0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;
        model_reset();

        // Reset state, with both requests already held.
        @(negedge clk);
        compare_outputs();
        check("rst_bus_read", bus_read, 0);
        check("rst_if_rdata", if_rdata, 32'h0);
        nrst = 1'b1;

        // Contention: data first after reset, then strict alternation.
        for (int g = 0; g < 4; g++) begin
            tick();
            exp_addr = (g % 2 == 0) ? 32'h2000 : 32'h1000;
            check("rr_grant_addr", bus_addr, exp_addr);
            bus_ack = 1'b1;
            tick();
            check("rr_d_ack", d_ack, (g % 2 == 0) ? 1 : 0);
            check("rr_if_ack", if_ack, (g % 2 == 0) ? 0 : 1);
            bus_ack = 1'b0;
            tick();
        end
        if_req = 1'b0;
        d_read = 1'b0;
        tick();

        // Single fetch with ack in the first access cycle.
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        check("fetch_bus_read", bus_read, 1);
        check("fetch_bus_addr", bus_addr, 32'h100);
        check("fetch_freeze", freeze, 1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0050_0093;
        tick();
        check("fetch_if_ack", if_ack, 1);
        check("fetch_if_rdata", if_rdata, 32'h0050_0093);
        check("fetch_strobe_low", bus_read, 0);
        check("fetch_freeze_ack", freeze, 0);
        if_req  = 1'b0;
        bus_ack = 1'b0;
        tick();

        // Store held until ack; later input changes must not reach the bus.
        d_write = 1'b1;
        d_addr  = 32'h7FC;
        d_wdata = 32'hCAFE_F00D;
        d_sel   = 4'b0011;
        tick();
        d_wdata = 32'h1234_5678;
        d_addr  = 32'h0;
        tick();
        check("store_bus_write", bus_write, 1);
        check("store_bus_read", bus_read, 0);
        check("store_bus_sel", bus_sel, 4'b0011);
        check("store_bus_wdata", bus_wdata, 32'hCAFE_F00D);
        check("store_bus_addr", bus_addr, 32'h7FC);
        bus_ack = 1'b1;
        tick();
        check("store_d_ack", d_ack, 1);
        d_write = 1'b0;
        bus_ack = 1'b0;
        tick();

        // Timeout: the access lasts TO cycles, then ack with err and zero data.
        d_read = 1'b1;
        d_addr = 32'h44;
        tick();
        n_acc = 0;
        seen  = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (bus_read) n_acc++;
            if (d_ack) begin
                seen = 1'b1;
                check("timeout_err", err, 1);
                check("timeout_rdata", d_rdata, 32'h0);
                check("timeout_cycles", n_acc, 4);
            end else begin
                tick();
            end
        end
        check("timeout_ack_seen", seen, 1);
        d_read = 1'b0;
        tick();

        // Read and write together is a write.
        d_read  = 1'b1;
        d_write = 1'b1;
        d_sel   = 4'b1000;
        tick();
        check("rw_bus_write", bus_write, 1);
        check("rw_bus_read", bus_read, 0);
        bus_ack = 1'b1;
        tick();
        d_read  = 1'b0;
        d_write = 1'b0;
        bus_ack = 1'b0;
        tick();

        // Reset mid-access: strobes drop at once, no ack, then normal service.
        d_read = 1'b1;
        d_addr = 32'h40;
        tick();
        check("midrst_pre_read", bus_read, 1);
        nrst = 1'b0;
        #1;
        check("midrst_read_low", bus_read, 0);
        check("midrst_no_ack", d_ack, 0);
        model_reset();
        bus_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
        nrst    = 1'b1;
        bus_ack = 1'b0;
        tick();
        check("midrst_reserve_addr", bus_addr, 32'h40);
        bus_ack   = 1'b1;
        bus_rdata = 32'hA5A5_0001;
        tick();
        check("midrst_reserve_ack", d_ack, 1);
        check("midrst_reserve_rdata", d_rdata, 32'hA5A5_0001);
        d_read  = 1'b0;
        bus_ack = 1'b0;
        tick();

        // Randomized traffic; requests hold until the model predicts their ack.
        for (int c = 0; c < 3000; c++) begin
            if (if_req) begin
                if (m_if_ack) if_req = 1'($urandom_range(0, 1));
            end else begin
                if_req = ($urandom_range(0, 2) == 0);
            end
            if (d_read || d_write) begin
                if (m_d_ack) begin
                    k       = int'($urandom_range(0, 5));
                    d_read  = (k == 1) || (k == 3);
                    d_write = (k == 2) || (k == 3);
                end
            end else begin
                k       = int'($urandom_range(0, 6));
                d_read  = (k == 1) || (k == 3);
                d_write = (k == 2) || (k == 3);
            end
            if_addr   = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_sel     = 4'($urandom_range(0, 15));
            bus_rdata = $urandom;
            bus_ack   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/t08_mem_arbiter.md
T08_MEM_ARBITER -- requirements
Module: t08_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: maximum number of cycles to wait for bus_ack before forcing an error completion.
REQ-002 Parameter DATA_FIRST, default 1'b1: which port wins a tie on the very first arbitration after reset (1 = data port).
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  instruction-fetch request, level; held until if_ack.
REQ-006 if_addr  in  32  fetch address.
REQ-007 if_rdata  out  32  fetched word, valid with if_ack.
REQ-008 if_ack  out  1  one-cycle completion pulse for the fetch port.
REQ-009 d_read, d_write  in  1 each  data load/store request, level; held until d_ack.
REQ-010 d_addr, d_wdata  in  32 each  data address and store data.
REQ-011 d_sel  in  4  byte-lane enables for stores.
REQ-012 d_rdata  out  32  load data, valid with d_ack.
REQ-013 d_ack  out  1  one-cycle completion pulse for the data port.
REQ-014 err  out  1  pulses together with the ack of any access that timed out.
REQ-015 bus_read, bus_write  out  1 each  downstream access strobes, held for the whole access.
REQ-016 bus_addr, bus_wdata  out  32 each  downstream address and write data.
REQ-017 bus_sel  out  4  downstream byte-lane enables (4'hF on reads).
REQ-018 bus_rdata  in  32  downstream read data, valid with bus_ack.
REQ-019 bus_ack  in  1  downstream completion, one cycle.
REQ-020 freeze  out  1  stall to the core: high while any request is pending and not yet acked.

Function
REQ-021 States: IDLE, ACCESS, DONE; reset state IDLE.
REQ-022 IDLE: if there are no requests, stay in IDLE. If exactly one port requests, grant it. If both request, grant the port that was not granted last (round-robin). Go to ACCESS.
REQ-023 On the IDLE->ACCESS edge, register the granted port's address, wdata, sel and direction.
- Bus strobes assert in the first ACCESS cycle, one cycle after the request is seen.
REQ-024 Bus outputs stay stable throughout ACCESS. Later changes on the requester inputs are ignored.
REQ-025 ACCESS with bus_ack: capture bus_rdata into the granted port's rdata register, pulse that port's ack the next cycle, and go to DONE.
REQ-026 Minimum latency from request to ack is 3 cycles when bus_ack arrives in the first ACCESS cycle.
REQ-027 DONE lasts exactly one cycle, with ack high and bus strobes low, then goes to IDLE. This gives the requester one cycle to drop or change its request.
REQ-028 Timeout counter (8-bit): clears on entering ACCESS and increments each ACCESS cycle without bus_ack.
- When it reaches TIMEOUT, complete as in REQ-025 but with rdata = 32'h0 and err = 1.
REQ-029 bus_ack together with the timeout in the same cycle: the ack wins and err stays 0.
REQ-030 d_read and d_write both high: treat as a write.
REQ-031 Stores drive bus_sel = d_sel. Reads and fetches drive bus_sel = 4'hF. Fetches never write.
REQ-032 if_rdata and d_rdata hold their last captured value until the next completion on the same port.
REQ-033 bus_ack outside ACCESS is ignored.
REQ-034 freeze = (if_req | d_read | d_write) & ~(if_ack | d_ack), combinational.
REQ-035 The last-grant flag updates only on grant. Its reset value selects the fetch port as "last" when DATA_FIRST = 1, and the data port otherwise.

Reset
REQ-036 When nrst is asserted, the block immediately enters IDLE and any in-flight access is aborted with no ack.
REQ-037 Reset values:
- all bus outputs 0;
- if_ack, d_ack, err 0;
- if_rdata, d_rdata 32'h0;
- timeout counter 0.
REQ-038 After nrst deasserts, the first arbitration follows REQ-035.

Verification
REQ-039 Single fetch: if_req, if_addr=32'h100, bus_ack at the first ACCESS cycle with bus_rdata=32'h00500093.
- Expect bus_read high for 1 cycle with bus_addr=32'h100, if_ack 3 cycles after the request, and if_rdata=32'h00500093.
REQ-040 Contention: if_req and d_read both held from reset, each bus_ack after 1 cycle.
- Expect grant order data, fetch, data, fetch, with each port acked alternately.
REQ-041 Store: d_write, d_addr=32'h7FC, d_wdata=32'hCAFE_F00D, d_sel=4'b0011.
- Expect bus_write with bus_sel=4'b0011 and bus_wdata=32'hCAFE_F00D held until bus_ack, then a d_ack pulse.
REQ-042 Timeout with TIMEOUT=4: d_read with bus_ack never asserted.
- Expect ACCESS to last 4 cycles, then d_ack and err pulsing together with d_rdata=0.
REQ-043 Reset mid-access: drop nrst during ACCESS.
- Expect bus strobes low immediately, no ack, and the request re-served normally after reset.
REQ-044 Read+write conflict: d_read=d_write=1.
- Expect only bus_write high.
